// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Captures bytes from a UART receiver through a ready/clear
//                handshake and queues them in a first-word-fall-through FIFO
//                with occupancy count and a sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_50mhz,
    input  logic          rst_n,
    input  logic          rx_data_ready,
    input  logic [7:0]    data_out,
    output logic          rx_clear_ready,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          overrun_clear
);

    localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_capture;
    logic          w_wr;
    logic          w_pop;
    logic          w_drop;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overrun;

    // Capture FSM state register; reset aborts any handshake in progress.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM next state: a byte is taken only on the IDLE->ACK step,
    // so a receiver holding rx_data_ready high is captured exactly once.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_data_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!rx_data_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign empty = (r_count == '0);
    assign full  = (r_count == c_full_count);

    // A pop on a full FIFO frees the slot the simultaneous write needs.
    assign w_pop  = rd_en & ~empty;
    assign w_wr   = w_capture & (~full | rd_en);
    assign w_drop = w_capture & full & ~rd_en;

    // Storage write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk_50mhz) begin
        if (rst_n && w_wr) begin
            r_mem[r_wr_ptr] <= data_out;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH == 2**AW.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count: simultaneous write and pop leave it unchanged.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overrun flag; a drop on the same edge as a clear wins.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

    assign rx_clear_ready = (r_state == ST_ACK);
    assign rd_data        = r_mem[r_rd_ptr];
    assign count          = r_count;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo using a queue-based
//                reference model plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          rx_data_ready;
    logic [7:0]    data_out;
    logic          rx_clear_ready;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          overrun_clear;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, handshake-busy flag, sticky overrun.
    logic [7:0] m_q[$];
    bit         m_busy  = 1'b0;
    bit         m_ovr   = 1'b0;
    bit         m_valid = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .clk_50mhz      (clk),
        .rst_n          (rst_n),
        .rx_data_ready  (rx_data_ready),
        .data_out       (data_out),
        .rx_clear_ready (rx_clear_ready),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overrun        (overrun),
        .overrun_clear  (overrun_clear)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_step();
        bit cap;
        bit pop;
        bit drop;
        if (!rst_n) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_ovr   = 1'b0;
            m_valid = 1'b1;
        end else begin
            cap  = !m_busy && rx_data_ready;
            pop  = rd_en && (m_q.size() > 0);
            drop = cap && (m_q.size() == DEPTH) && !rd_en;
            if (pop) void'(m_q.pop_front());
            if (cap && !drop) m_q.push_back(data_out);
            if (drop) m_ovr = 1'b1;
            else if (overrun_clear) m_ovr = 1'b0;
            if (cap) m_busy = 1'b1;
            else if (!rx_data_ready) m_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rx_raise(input logic [7:0] b, input logic rd, input logic clr);
        rx_data_ready = 1'b1;
        data_out      = b;
        rd_en         = rd;
        overrun_clear = clr;
        tick();
        rd_en         = 1'b0;
        overrun_clear = 1'b0;
    endtask

    task automatic rx_fall();
        rx_data_ready = 1'b0;
        tick();
    endtask

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_count", 32'(count), 32'(m_q.size()));
            chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
            chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("m_overrun", 32'(overrun), 32'(m_ovr));
            chk("m_rx_clear_ready", 32'(rx_clear_ready), 32'(m_busy));
            if (m_q.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(m_q[0]));
        end
    end

    initial begin
        int rdprob;
        rst_n         = 1'b0;
        rx_data_ready = 1'b0;
        data_out      = 8'h00;
        rd_en         = 1'b0;
        overrun_clear = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_ack", 32'(rx_clear_ready), 0);
        rst_n = 1'b1;
        tick();

        // Single byte held for three edges
        rx_raise(8'hA5, 1'b0, 1'b0);
        chk("one_count", 32'(count), 1);
        chk("one_data", 32'(rd_data), 32'h A5);
        chk("one_ack1", 32'(rx_clear_ready), 1);
        tick();
        tick();
        chk("one_ack3", 32'(rx_clear_ready), 1);
        chk("one_count3", 32'(count), 1);
        rx_fall();
        chk("one_ackoff", 32'(rx_clear_ready), 0);

        // Pop it, then pop on empty
        rd_en = 1'b1;
        tick();
        chk("pop_empty", 32'(empty), 1);
        tick();
        rd_en = 1'b0;
        chk("pop_on_empty_count", 32'(count), 0);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            rx_raise(8'(i), 1'b0, 1'b0);
            rx_fall();
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_head", 32'(rd_data), 0);
        rx_raise(8'h55, 1'b0, 1'b0);
        chk("drop_overrun", 32'(overrun), 1);
        chk("drop_ack", 32'(rx_clear_ready), 1);
        chk("drop_count", 32'(count), 16);
        rx_fall();
        chk("drop_head", 32'(rd_data), 0);

        // Overrun clear, then drop+clear at the same edge
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        chk("ovr_clear", 32'(overrun), 0);
        rx_raise(8'h66, 1'b0, 1'b1);
        chk("ovr_prio", 32'(overrun), 1);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        chk("ovr_clear2", 32'(overrun), 0);
        rx_fall();

        // Full plus pop at capture edge
        rx_raise(8'h77, 1'b1, 1'b0);
        chk("fp_count", 32'(count), 16);
        chk("fp_overrun", 32'(overrun), 0);
        chk("fp_head", 32'(rd_data), 1);
        rx_fall();
        rd_en = 1'b1;
        repeat (15) tick();
        rd_en = 1'b0;
        chk("fp_tail", 32'(rd_data), 32'h77);
        chk("fp_tail_count", 32'(count), 1);

        // Reset during ACK, byte recaptured afterwards
        rx_raise(8'h3C, 1'b0, 1'b0);
        chk("ra_pre_count", 32'(count), 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ra_count", 32'(count), 0);
        chk("ra_ack", 32'(rx_clear_ready), 0);
        tick();
        chk("ra_recount", 32'(count), 1);
        chk("ra_redata", 32'(rd_data), 32'h3C);
        chk("ra_reack", 32'(rx_clear_ready), 1);
        rx_fall();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

        // 20 bytes interleaved with reads, crossing the pointer wrap
        for (int i = 0; i < 20; i++) begin
            rx_raise(8'hC0 + 8'(i), (i >= 4) ? 1'b1 : 1'b0, 1'b0);
            rx_fall();
        end
        for (int i = 16; i < 20; i++) begin
            chk("wrap_order", 32'(rd_data), 32'(8'hC0 + 8'(i)));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_count", 32'(count), 0);

        // Randomized traffic with varying consumer rate
        rdprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rdprob = 10;
                    1:       rdprob = 50;
                    default: rdprob = 90;
                endcase
            end
            rx_data_ready = ($urandom_range(0, 99) < 45);
            data_out      = 8'($urandom);
            rd_en         = ($urandom_range(0, 99) < rdprob);
            overrun_clear = ($urandom_range(0, 19) == 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n         = 1'b1;
        rx_data_ready = 1'b0;
        rd_en         = 1'b0;
        overrun_clear = 1'b0;
        tick();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL take parameter DEPTH, default 16, meaning FIFO entries; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL take parameter AW, default 4, meaning address width; AW SHALL equal log2(DEPTH).
REQ-003 The block SHALL have port clk_50mhz, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port rx_data_ready, input, width 1: the receiver holds a byte.
REQ-006 The block SHALL have port data_out, input, width 8: the receiver byte, valid while rx_data_ready=1.
REQ-007 The block SHALL have port rx_clear_ready, output, width 1: the acknowledge to the receiver.
REQ-008 The block SHALL have port rd_en, input, width 1: the consumer pop request.
REQ-009 The block SHALL have port rd_data, output, width 8: the FIFO head in first-word-fall-through mode.
REQ-010 The block SHALL have port empty, output, width 1: the FIFO holds 0 entries.
REQ-011 The block SHALL have port full, output, width 1: the FIFO holds DEPTH entries.
REQ-012 The block SHALL have port count, output, width AW+1: the number of occupied entries.
REQ-013 The block SHALL have port overrun, output, width 1: a sticky flag meaning a byte was dropped.
REQ-014 The block SHALL have port overrun_clear, input, width 1: clears overrun.

Function
REQ-015 The capture FSM SHALL have two states, IDLE and ACK, with rx_clear_ready=1 exactly while in ACK (registered output).
REQ-016 In IDLE with rx_data_ready=1, the capture FSM SHALL write data_out at that edge if (!full || rd_en), else drop the byte and set overrun; in both cases it SHALL go to ACK.
REQ-017 In ACK the capture FSM SHALL remain until rx_data_ready is sampled 0, then return to IDLE; no write occurs in ACK, so each byte is captured exactly once.
REQ-018 Storage SHALL be DEPTH x 8 with wr_ptr and rd_ptr of AW bits each, wrapping from DEPTH-1 to 0.
REQ-019 rd_data SHALL equal mem[rd_ptr] combinationally; it is don't-care when empty.
REQ-020 rd_en with empty=0 SHALL advance rd_ptr at the edge; rd_en with empty=1 SHALL be ignored, with no pointer or count change.
REQ-021 count SHALL update as follows: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
REQ-022 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH).
REQ-023 When full=1 and rd_en=1 coincide with a capture, the pop and the write SHALL both occur, count SHALL stay DEPTH, and overrun SHALL not be set.
REQ-024 Byte latency SHALL be: a byte written at edge N appears on rd_data with empty=0 after edge N.
REQ-025 overrun SHALL be set on a drop and cleared by overrun_clear=1; if a drop and overrun_clear=1 occur at the same edge, set SHALL win.
REQ-026 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-027 With rst_n=0 at an edge, the block SHALL go to IDLE with wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0 and rx_clear_ready=0; memory contents are not reset.
REQ-028 A reset while in ACK SHALL abort the handshake; if rx_data_ready is still 1 after reset, that byte SHALL be captured again as a new byte.
REQ-029 rd_en and rx_data_ready SHALL be ignored while rst_n=0.

Verification
REQ-030 Single byte: rx_data_ready=1 with data_out=0xA5 for 3 cycles -> one write, count=1, rd_data=0xA5, rx_clear_ready=1 from the next cycle until rx_data_ready falls, then 0.
REQ-031 Fill (DEPTH=16): 16 bytes 0x00..0x0F with no reads -> full=1 and count=16; a 17th byte 0x55 -> dropped, overrun=1, rx_clear_ready still pulsed, contents unchanged.
REQ-032 Full plus pop: when full, byte 0x77 arrives with rd_en=1 -> 0x00 popped, 0x77 stored at the tail, count=16, overrun=0.
REQ-033 Drain and wrap: write 20 bytes interleaved with reads -> read order identical to write order across the pointer wrap; rd_en on empty -> no change.
REQ-034 Overrun priority: drop and overrun_clear=1 at the same edge -> overrun=1; overrun_clear alone on the next edge -> overrun=0.
REQ-035 Reset in ACK: rst_n=0 for 1 cycle while rx_data_ready=1 -> count=0 and rx_clear_ready=0 after reset; the byte is then recaptured, giving count=1.
